booth_seq_ctrl: RTL
===================

Name: booth_seq_ctrl

Overview:
- Sequential radix-2 Booth multiplier controller with its shift/add datapath.
- Accepts two signed operands after the keypad input stage reports both operands ready.
- Runs one Booth iteration per clock, then holds the signed product for the BCD/display path.
- Sits between input_module/output_control and bin_to_bcd. Replaces the direct state-signal feed into the converter.

Parameters:
- WIDTH, 8, operand width in bits (two's complement); product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiplication; sampled only in IDLE.
- clear  input  1  synchronous abort/clear: return to IDLE and invalidate product.
- operand_a  input  WIDTH  multiplicand M (signed), captured on accepted start.
- operand_b  input  WIDTH  multiplier Q (signed), captured on accepted start.
- busy  output  1  high in LOAD, ITER, DONE.
- done  output  1  one-cycle pulse in DONE state.
- product  output  2*WIDTH  signed result; held until next accepted start or clear.
- product_valid  output  1  high from DONE until next accepted start, clear or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, product=0, product_valid=0. All internal registers are 0.
- States and transitions:
  - IDLE: if start=1 and clear=0, go to LOAD. Capture operand_a/operand_b. product_valid <= 0.
  - LOAD: acc <= 0 (WIDTH+1 bits); M <= sign-extend(operand_a) to WIDTH+1; Q <= operand_b; q_1 <= 0; cnt <= WIDTH-1. Next: ITER.
  - ITER: one iteration per cycle, selected by {Q[0],q_1}:
    - 01: acc += M.
    - 10: acc -= M.
    - 00/11: no change.
  - ITER, same cycle: arithmetic right shift of {acc', Q, q_1} by one. acc' is the post-add value; its MSB is replicated.
  - ITER exit: if cnt==0, go to DONE; else cnt <= cnt-1.
  - DONE: product <= {acc[WIDTH-1:0], Q}; product_valid <= 1; done=1 for this cycle only. Next: IDLE.
- Latency: start accepted at edge k; done high during cycle k+WIDTH+2 (LOAD 1 + ITER WIDTH + DONE 1). For WIDTH=8, done appears 10 cycles after the accepting edge.
- Accumulator is WIDTH+1 bits, so negating M=-2^(WIDTH-1) never overflows. -128*-128 is exact.
- start while busy=1 (including the DONE cycle) is ignored, not queued.
- Operand inputs may change freely after acceptance; only captured values are used.
- clear=1 in any state: next state IDLE; product=0; product_valid=0; done=0. clear has priority over start in the same cycle.
- rst asserted mid-operation: immediate return to reset values; no done pulse.
- done and product_valid update on the same edge; product is stable whenever product_valid=1.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package booth_pkg holds:
  - typedef enum state_t {IDLE, LOAD, ITER, DONE}, 2 bits;
  - constant DEFAULT_WIDTH=8;
  - Booth op encoding constants BOOTH_NOP/BOOTH_ADD/BOOTH_SUB.
- One sub-module is natural: booth_step. It is purely combinational: (acc, M, Q, q_1) -> shifted (acc, Q, q_1). The FSM, counter and output registers stay in booth_seq_ctrl.

Test Plan:
- operand_a=7, operand_b=3, start pulse -> busy high next cycle; done pulse 10 cycles after accept; product=0x0015; product_valid=1 held.
- operand_a=-5 (0xFB), operand_b=7 -> product=0xFFDD (-35); then operand_a=-128, operand_b=-128 -> product=0x4000.
- operand_a=0x7F, operand_b=-128 -> product=0xC080 (-16256); operand_a=0, operand_b=0x55 -> product=0x0000.
- Extra start pulses on cycles 3 and 10 (DONE) of a run with 6*6 -> both ignored; one done pulse; product=0x0024; no second run starts.
- clear on cycle 5 of a run -> IDLE next cycle; product=0, product_valid=0, no done. Repeat with rst on cycle 5: immediate reset values. Then a new 2*-2 run -> product=0xFFFC.
- Back-to-back: start asserted the cycle after done with new operands 9,9 -> product_valid drops on accept; next done gives product=0x0051.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Holds the controller state encoding and the Booth recoding helpers.
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [1:0] booth_op_t;

    localparam booth_op_t BOOTH_NOP = 2'd0;
    localparam booth_op_t BOOTH_ADD = 2'd1;
    localparam booth_op_t BOOTH_SUB = 2'd2;

    // Radix-2 recoding of the {Q[0], q_1} bit pair.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M followed
// by an arithmetic right shift of the {acc, Q, q_1} register chain.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             q_1_nxt
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], q_1))
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        // Shift uses the post-add accumulator; its sign bit is replicated.
        acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt   = {sum[0], q[WIDTH-1:1]};
        q_1_nxt = q[0];
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, product held
// for the BCD/display path until the next accepted start or clear.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// LOAD  | initialise acc, M, Q, q_1 and iteration counter
// ITER  | one Booth add/sub + arithmetic shift per cycle
// DONE  | publish product, pulse done, return to IDLE
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               product_valid
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               q_1;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     acc_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               q_1_nxt;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc     (acc),
        .m       (m_reg),
        .q       (q_reg),
        .q_1     (q_1),
        .acc_nxt (acc_nxt),
        .q_nxt   (q_nxt),
        .q_1_nxt (q_1_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cap_a         <= '0;
            cap_b         <= '0;
            acc           <= '0;
            m_reg         <= '0;
            q_reg         <= '0;
            q_1           <= 1'b0;
            cnt           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else if (clear) begin
            // Abort wins over start and over any in-flight iteration.
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            product       <= '0;
            product_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cap_a         <= operand_a;
                        cap_b         <= operand_b;
                        product_valid <= 1'b0;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    m_reg <= {cap_a[WIDTH-1], cap_a};
                    q_reg <= cap_b;
                    q_1   <= 1'b0;
                    cnt   <= CNT_W'(WIDTH - 1);
                    state <= ITER;
                end
                ITER: begin
                    acc   <= acc_nxt;
                    q_reg <= q_nxt;
                    q_1   <= q_1_nxt;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    product       <= {acc[WIDTH-1:0], q_reg};
                    product_valid <= 1'b1;
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
